data_memory_ctrl: RTL
=====================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the array (power of 2).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of WAIT cycles per access (legal range 1..15).
REQ-003 The block SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port MemRead, input, 1, load request from control.
REQ-006 The block SHALL have port MemWrite, input, 1, store request from control.
REQ-007 The block SHALL have port Addr, input, 32, byte address, driven by the datapath ALU result.
REQ-008 The block SHALL have port WriteData, input, 32, store data (rt value); the byte is in bits [7:0] and the halfword in bits [15:0].
REQ-009 The block SHALL have port Size, input, 2, access width: 00 word, 01 halfword, 10 byte, 11 illegal.
REQ-010 The block SHALL have port Unsigned, input, 1, which selects zero-extension for byte and halfword loads; 0 selects sign-extension.
REQ-011 The block SHALL have port ReadData, output, 32, load result returned to the datapath write-back mux.
REQ-012 The block SHALL have port Stall, output, 1, freeze request to the PC and register-file write enable.
REQ-013 The block SHALL have port Misaligned, output, 1, alignment/size error flag for the current request.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-015 A request SHALL be MemRead|MemWrite; when both are asserted, MemWrite SHALL win and the access SHALL be a store.
REQ-016 Misaligned SHALL be combinational, asserted only in IDLE with a request pending and one of: Size=00 with Addr[1:0]!=0; Size=01 with Addr[0]!=0; or Size=11.
REQ-017 A misaligned request SHALL cause no state change, no memory write, no Stall, and no change to ReadData.
REQ-018 Stall SHALL be combinational: 1 in IDLE with an aligned request pending, 1 throughout WAIT, 0 in DONE, and 0 otherwise.
REQ-019 IDLE->WAIT SHALL occur on the edge where an aligned request is seen; at that edge the block SHALL latch Addr, WriteData, Size, Unsigned and the read/write kind, and load the counter with LATENCY-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle, and all request inputs SHALL be ignored.
REQ-021 WAIT->DONE SHALL occur on the edge where the counter equals 0, so WAIT lasts exactly LATENCY cycles.
REQ-022 On the WAIT->DONE edge, a store SHALL update only the addressed lanes: word writes all 4 bytes, halfword writes lanes Addr[1] (bytes 1:0 or 3:2), byte writes lane Addr[1:0].
REQ-023 On the WAIT->DONE edge, a load SHALL register the extracted lane, extended per Unsigned, into ReadData.
REQ-024 DONE->IDLE SHALL occur unconditionally after one cycle; in DONE the requester still presents the same instruction and advances at the end of that cycle.
REQ-025 A full access SHALL take LATENCY+2 cycles, of which LATENCY+1 have Stall=1.
REQ-026 Byte order SHALL be little-endian: byte lane 0 is bits [7:0].
REQ-027 The word index SHALL be Addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-028 ReadData SHALL hold its value until the next load completes; stores SHALL NOT change ReadData.
REQ-029 Back-to-back requests SHALL be allowed: a request present in the first IDLE cycle after DONE starts immediately, with no bubble.

Reset
REQ-030 Reset low SHALL immediately force state=IDLE, counter=0, ReadData=0, Stall=0 and Misaligned=0, independent of CLK.
REQ-031 Reset asserted during WAIT SHALL abort the access, and an aborted store SHALL leave memory unmodified.
REQ-032 The memory array SHALL NOT be cleared by reset; its contents survive reset.
REQ-033 After reset deasserts, the first rising edge with an aligned request SHALL start an access normally.

Verification
REQ-034 Word store then load (LATENCY=2): store 0xDEADBEEF to 0x10, then load word 0x10 -> Stall high 3 cycles per access, ReadData=0xDEADBEEF in the DONE cycle of the load.
REQ-035 Sub-word accesses: word 0x80 holds 0x12345678; store byte 0xAA to 0x81 -> word reads 0x1234AA78. Then load byte 0x81 signed -> 0xFFFFFFAA; load byte 0x81 unsigned -> 0x000000AA; load half 0x82 signed -> 0x00001234.
REQ-036 Misalignment: load word at 0x22, or Size=11 -> Misaligned=1, Stall=0, ReadData unchanged, memory unchanged, state remains IDLE.
REQ-037 Wrap-around (DEPTH_WORDS=256): store 0x5 to 0x400 -> load word 0x0 returns 0x5.
REQ-038 Reset mid-access: store 0xCAFE0000 to 0x40, then drive reset low in the 2nd WAIT cycle -> Stall=0 at once, and a later load of 0x40 returns the old value.
REQ-039 Simultaneous requests: MemRead=MemWrite=1 with word at 0x8 and WriteData=0x77 -> treated as a store, word 0x8 becomes 0x77, ReadData unchanged.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory controller: word/half/byte loads and stores into a
// little-endian 32-bit array, stalling the requester for LATENCY+1 cycles.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Misaligned
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t          r_state, w_next_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_off, r_size;
    logic [31:0]     r_wdata;
    logic            r_uns, r_write;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req, w_mis, w_start, w_finish, w_unused;
    logic [31:0]     w_word, w_lane_data, w_merged, w_load;
    logic [3:0]      w_be;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_req    = MemRead | MemWrite;
    assign w_mis    = (Size == 2'b11) ||
                      (Size == 2'b00 && Addr[1:0] != 2'b00) ||
                      (Size == 2'b01 && Addr[0]);
    assign w_start  = (r_state == S_IDLE) && w_req && !w_mis;
    assign w_finish = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Upper address bits fold onto the array (addresses wrap).
    assign w_unused = ^Addr[31:AW+2];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are gated by reset so they drop immediately, even with a request held.
    always_comb begin
        Stall      = 1'b0;
        Misaligned = 1'b0;
        if (reset) begin
            case (r_state)
                S_IDLE: begin
                    Stall      = w_req && !w_mis;
                    Misaligned = w_req && w_mis;
                end
                S_WAIT:  Stall = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_off   <= 2'd0;
            r_size  <= 2'd0;
            r_wdata <= 32'd0;
            r_uns   <= 1'b0;
            r_write <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= CNT_INIT;
            r_idx   <= Addr[AW+1:2];
            r_off   <= Addr[1:0];
            r_size  <= Size;
            r_wdata <= WriteData;
            r_uns   <= Unsigned;
            r_write <= MemWrite;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_word = r_mem[r_idx];
    assign w_byte = w_word[{r_off, 3'b000} +: 8];
    assign w_half = w_word[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = r_wdata;
        w_load      = w_word;
        case (r_size)
            2'b00: w_be = 4'b1111;
            2'b01: begin
                w_be        = r_off[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{r_wdata[15:0]}};
                w_load      = {{16{w_half[15] & ~r_uns}}, w_half};
            end
            2'b10: begin
                w_be        = 4'b0001 << r_off;
                w_lane_data = {4{r_wdata[7:0]}};
                w_load      = {{24{w_byte[7] & ~r_uns}}, w_byte};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 4; b++)
            if (w_be[b]) w_merged[8*b +: 8] = w_lane_data[8*b +: 8];
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                    ReadData <= 32'd0;
        else if (w_finish && !r_write) ReadData <= w_load;
    end

    // Array has no reset; contents persist across reset.
    always_ff @(posedge CLK) begin
        if (w_finish && r_write) r_mem[r_idx] <= w_merged;
    end
endmodule
